// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_capture
//
// Triggered snapshot capture behind the JESD204 TPL ADC core, in the link_clk
// domain. After an arm request, the block waits for the trigger. It then
// buffers a programmed number of converter beats in a small FIFO and streams
// them out as one AXI-Stream packet, with tlast on the final beat. A beat that
// cannot be stored because the FIFO is full is reported on adc_dovf, which
// feeds the TPL regmap overflow input.
//
// Ports
//   clk              link_clk; every register is clocked by it
//   resetn           asynchronous active-low reset
//   adc_valid        per-channel valid from the TPL (any bit set = beat present)
//   adc_data         converter beat from the TPL
//   adc_dovf         one-cycle pulse per beat dropped while capturing
//   capture_arm      single-cycle arm request, honoured only when idle
//   capture_len      beats to capture, sampled with an accepted arm
//   capture_trigger  level trigger, qualified with a valid beat
//   capture_busy     high from an accepted arm until the packet has left
//   capture_done     one-cycle pulse after the last beat's handshake
//   capture_ovf      sticky "a beat was dropped", cleared by the next arm
//   m_axis_*         registered AXI-Stream master towards the DMA
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_capture #(
    parameter int DATA_WIDTH      = 128,
    parameter int NUM_CHANNELS    = 4,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int LEN_WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CHANNELS-1:0] adc_valid,
    input  logic [DATA_WIDTH-1:0]   adc_data,
    output logic                    adc_dovf,
    input  logic                    capture_arm,
    input  logic [LEN_WIDTH-1:0]    capture_len,
    input  logic                    capture_trigger,
    output logic                    capture_busy,
    output logic                    capture_done,
    output logic                    capture_ovf,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic                    m_axis_last
);

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

    localparam logic [FIFO_ADDR_WIDTH:0]   OCC_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [FIFO_ADDR_WIDTH:0]   OCC_FULL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]       LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]       LEN_ZERO = '0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]                 state;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [LEN_WIDTH-1:0]       cnt_q;
    logic [LEN_WIDTH-1:0]       cnt_inc;

    // Each FIFO word carries its tlast tag in the top bit.
    logic [DATA_WIDTH:0]        mem [0:DEPTH-1];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_nxt;
    // Occupancy counts every word not yet handshaken, including the one
    // currently presented on m_axis_*. It is one bit wider than the pointers,
    // so "full" and "empty" stay distinct when the pointers are equal.
    logic [FIFO_ADDR_WIDTH:0]   occ;
    logic [FIFO_ADDR_WIDTH:0]   avail;

    logic in_valid;
    logic pop;
    logic fifo_full;
    logic wr_req;
    logic wr_acc;
    logic wr_drop;
    logic wr_last;

    always_comb begin
        in_valid  = |adc_valid;
        pop       = m_axis_valid && m_axis_ready;
        fifo_full = (occ == OCC_FULL);
        cnt_inc   = cnt_q + LEN_ONE;

        // The trigger beat itself is the first captured word. CAPTURE stops
        // requesting once len words are buffered. That case only lingers in
        // CAPTURE for a single-beat capture, whose only word was written in
        // ARMED.
        wr_req = in_valid &&
                 (((state == ST_ARMED) && capture_trigger) ||
                  ((state == ST_CAPTURE) && (cnt_q != len_q)));

        // Being full is not fatal when the head word leaves on the same edge.
        wr_acc  = wr_req && (!fifo_full || pop);
        wr_drop = wr_req && fifo_full && !pop;
        wr_last = (cnt_inc == len_q);

        rd_ptr_nxt = pop ? (rd_ptr + PTR_ONE) : rd_ptr;

        // Number of words already in memory once this edge's pop is taken
        // out. A word written on this same edge is excluded. That gives the
        // one-cycle write-to-valid latency, and it guarantees the output
        // register never reads the location being written.
        avail = pop ? (occ - OCC_ONE) : occ;

        capture_busy = (state != ST_IDLE);
    end

    // ---- capture control: state, length, counter, status pulses ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            capture_ovf  <= 1'b0;
            capture_done <= 1'b0;
            adc_dovf     <= 1'b0;
        end else begin
            capture_done <= 1'b0;
            adc_dovf     <= wr_drop && (state == ST_CAPTURE);

            if (wr_drop && (state == ST_CAPTURE)) begin
                capture_ovf <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (capture_arm && (capture_len != LEN_ZERO)) begin
                        len_q       <= capture_len;
                        cnt_q       <= '0;
                        capture_ovf <= 1'b0;
                        state       <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // The FIFO is always empty here, so the trigger beat
                    // is never dropped.
                    if (wr_acc) begin
                        cnt_q <= cnt_inc;
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (cnt_q == len_q) begin
                        state <= ST_DRAIN;
                    end else if (wr_acc) begin
                        cnt_q <= cnt_inc;
                        if (wr_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_axis_last) begin
                        capture_done <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- FIFO write side and occupancy ----
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {wr_last, adc_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
            case ({wr_acc, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // ---- registered AXI-Stream output: next head word ----
    // The output holds while valid and not ready, because then avail == occ
    // and rd_ptr_nxt == rd_ptr. When the FIFO runs dry, the old data is kept
    // and only valid falls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
        end else begin
            m_axis_valid <= (avail != '0);
            if (avail != '0) begin
                {m_axis_last, m_axis_data} <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule
